// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and storage-facing width defaults for the memory port arbiter.
package mem_port_arbiter_pkg;

  // Must track the storage block's READ_ADDR_SIZE and ROW_WIDTH.
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Round-robin winner pick: first req above 'last', wrapping; combinational, one-hot out.
module rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     win
);

  // Wrapped candidates first, then those above 'last' override; descending loops keep the lowest index.
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) <= last)) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) > last)) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one storage port; grant one cycle after req, done WAIT_CYCLES later.
// No backpressure: requesters hold req stable until gnt, requests are only sampled in IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int AMT_REQ     = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AMT_REQ-1:0]        req,
  input  logic [AMT_REQ-1:0]        req_we,
  input  logic [ADDR_W*AMT_REQ-1:0] req_addr,
  input  logic [DATA_W*AMT_REQ-1:0] req_wdata,
  output logic [AMT_REQ-1:0]        gnt,
  output logic [AMT_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (AMT_REQ > 1) ? $clog2(AMT_REQ) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last, idx, win_idx;
  logic [AMT_REQ-1:0] win;
  logic [CNT_W-1:0]   cnt;
  logic               we_q, grant, finish, sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  rr_select #(
    .N     (AMT_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req  (req),
    .last (last),
    .win  (win)
  );

  always_comb begin
    win_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < AMT_REQ; i++) begin
      if (win[i]) begin
        win_idx   = IDX_W'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = ACCESS;
          grant     = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Derived from the async-reset state, so a reset drops the write strobe immediately.
  assign busy   = (state != IDLE);
  assign mem_we = (state == ACCESS) && (cnt == '0) && we_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      last      <= '0;
      idx       <= '0;
      we_q      <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      if (grant) begin
        idx       <= win_idx;
        last      <= win_idx;
        we_q      <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        cnt       <= CNT_W'(WAIT_CYCLES - 1);
        gnt       <= win;
      end else if ((state == ACCESS) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (finish) begin
        done[idx] <= 1'b1;
        if (!we_q) rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (WAIT_CYCLES 1, 3, 4) share stimulus; each test targets one.
module tb_mem_port_arbiter;

  localparam int NU = 3;
  localparam int WC [NU] = '{1, 3, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  req_we = '0;
  logic [27:0] addr0 = 28'h10, addr1 = 28'h20;
  logic [31:0] wd0 = '0, wd1 = '0;

  logic [1:0]  gnt_o   [NU];
  logic [1:0]  done_o  [NU];
  logic [31:0] rdata_o [NU];
  logic        busy_o  [NU];
  logic [27:0] maddr_o [NU];
  logic [31:0] mwd_o   [NU];
  logic        mwe_o   [NU];
  logic [31:0] mrd     [NU];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [27:0] a);
    return (a == 28'h10) ? 32'hDEADBEEF : (32'hA500_0000 | {4'h0, a});
  endfunction

  for (genvar g = 0; g < NU; g++) begin : g_dut
    assign mrd[g] = mem_model(maddr_o[g]);
    mem_port_arbiter #(
      .ADDR_W      (28),
      .DATA_W      (32),
      .AMT_REQ     (2),
      .WAIT_CYCLES (WC[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_we    (req_we),
      .req_addr  ({addr1, addr0}),
      .req_wdata ({wd1, wd0}),
      .gnt       (gnt_o[g]),
      .done      (done_o[g]),
      .rdata     (rdata_o[g]),
      .busy      (busy_o[g]),
      .mem_addr  (maddr_o[g]),
      .mem_wdata (mwd_o[g]),
      .mem_we    (mwe_o[g]),
      .mem_rdata (mrd[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int u, input string tag, input logic [1:0] eg, input logic [1:0] ed,
                     input logic eb, input logic emwe, input logic [31:0] erd);
    chk($sformatf("%s u%0d gnt", tag, u), 32'(gnt_o[u]), 32'(eg));
    chk($sformatf("%s u%0d done", tag, u), 32'(done_o[u]), 32'(ed));
    chk($sformatf("%s u%0d busy", tag, u), 32'(busy_o[u]), 32'(eb));
    chk($sformatf("%s u%0d mem_we", tag, u), 32'(mwe_o[u]), 32'(emwe));
    chk($sformatf("%s u%0d rdata", tag, u), rdata_o[u], erd);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    req    = '0;
    req_we = '0;
    addr0  = 28'h10;
    addr1  = 28'h20;
    wd0    = '0;
    wd1    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        busy;
    logic        mwe;
    logic [31:0] rdata;
  } vec_t;

  localparam logic [31:0] RA = 32'hA500_0020;
  localparam logic [31:0] RB = 32'hDEADBEEF;

  vec_t tv [22];

  initial begin
    // Contention, withdrawal, single read and late request, all on the WAIT_CYCLES=1 instance.
    tv[0]  = '{2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 32'h0};
    tv[1]  = '{2'b11, 2'b00, 2'b10, 1'b1, 1'b0, RA};
    tv[2]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, RA};
    tv[3]  = '{2'b11, 2'b01, 2'b00, 1'b1, 1'b0, RA};
    tv[4]  = '{2'b11, 2'b00, 2'b01, 1'b1, 1'b0, RB};
    tv[5]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, RB};
    tv[6]  = '{2'b11, 2'b10, 2'b00, 1'b1, 1'b0, RB};
    tv[7]  = '{2'b00, 2'b00, 2'b10, 1'b1, 1'b0, RA};
    tv[8]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, RA};
    tv[9]  = '{2'b10, 2'b10, 2'b00, 1'b1, 1'b0, RA};
    tv[10] = '{2'b01, 2'b00, 2'b10, 1'b1, 1'b0, RA};
    tv[11] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, RA};
    tv[12] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, RA};
    tv[13] = '{2'b01, 2'b01, 2'b00, 1'b1, 1'b0, RA};
    tv[14] = '{2'b00, 2'b00, 2'b01, 1'b1, 1'b0, RB};
    tv[15] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, RB};
    tv[16] = '{2'b10, 2'b10, 2'b00, 1'b1, 1'b0, RB};
    tv[17] = '{2'b01, 2'b00, 2'b10, 1'b1, 1'b0, RA};
    tv[18] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, RA};
    tv[19] = '{2'b01, 2'b01, 2'b00, 1'b1, 1'b0, RA};
    tv[20] = '{2'b00, 2'b00, 2'b01, 1'b1, 1'b0, RB};
    tv[21] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, RB};

    // Reset state on every instance while rst is held low.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      cyc(u, "reset", 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
      chk($sformatf("reset u%0d mem_addr", u), 32'(maddr_o[u]), 32'h0);
      chk($sformatf("reset u%0d mem_wdata", u), mwd_o[u], 32'h0);
    end
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      req = tv[i].req;
      step();
      cyc(0, $sformatf("vec%0d", i), tv[i].gnt, tv[i].done, tv[i].busy, tv[i].mwe, tv[i].rdata);
    end

    // Write with WAIT_CYCLES=3: strobe only in the last access cycle, rdata untouched.
    do_reset();
    addr1  = 28'h5;
    wd1    = 32'h1234;
    req_we = 2'b10;
    req    = 2'b10;
    step();
    cyc(1, "wr c1", 2'b10, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("wr c1 mem_addr", 32'(maddr_o[1]), 32'h5);
    req = 2'b00;
    step();
    cyc(1, "wr c2", 2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("wr c2 mem_addr", 32'(maddr_o[1]), 32'h5);
    step();
    cyc(1, "wr c3", 2'b00, 2'b00, 1'b1, 1'b1, 32'h0);
    chk("wr c3 mem_addr", 32'(maddr_o[1]), 32'h5);
    chk("wr c3 mem_wdata", mwd_o[1], 32'h1234);
    step();
    cyc(1, "wr c4", 2'b00, 2'b10, 1'b1, 1'b0, 32'h0);
    step();
    cyc(1, "wr c5", 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("wr c5 mem_addr hold", 32'(maddr_o[1]), 32'h5);

    // Reset in access cycle 2 of a WAIT_CYCLES=4 write granted to requester 1.
    do_reset();
    addr1  = 28'h5;
    wd1    = 32'h55AA;
    req_we = 2'b10;
    req    = 2'b10;
    step();
    chk("abort c1 gnt", 32'(gnt_o[2]), 32'h2);
    req = 2'b00;
    step();
    chk("abort c2 busy", 32'(busy_o[2]), 32'h1);
    #2 rst = 1'b0;
    #1;
    cyc(2, "abort rst", 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("abort idle%0d done", c), 32'(done_o[2]), 32'h0);
      chk($sformatf("abort idle%0d busy", c), 32'(busy_o[2]), 32'h0);
    end
    req = 2'b11;
    step();
    chk("abort next gnt", 32'(gnt_o[2]), 32'h2);
    req = 2'b00;

    // Async reset in the final access cycle of a WAIT_CYCLES=1 write drops the strobe at once.
    do_reset();
    addr1  = 28'h5;
    wd1    = 32'h77;
    req_we = 2'b10;
    req    = 2'b10;
    step();
    chk("async mem_we before", 32'(mwe_o[0]), 32'h1);
    req = 2'b00;
    #2 rst = 1'b0;
    #1;
    cyc(0, "async rst", 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("async idle%0d done", c), 32'(done_o[0]), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
